// File: rtl/game_pkg.sv
// Shared game constants: default game length, timer state encoding and BCD helpers.
package game_pkg;

   localparam int GAME_SECONDS_DEF = 30;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      EXPIRED = 2'd2
   } timer_state_t;

   // Elaboration-time only; the running digits are maintained by borrow logic.
   function automatic logic [3:0] bcd_tens(input int v);
      return 4'(v / 10);
   endfunction

   function automatic logic [3:0] bcd_ones(input int v);
      return 4'(v % 10);
   endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchronizer plus rising-edge detector for a slow asynchronous strobe.
// Emits a one-cycle tick on each rise seen after the input has been observed low.
module tick_sync (
   input  logic clkIn,
   input  logic reset,
   input  logic async_in,
   output logic tick_out
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic vld_q,   vld_d;
   logic armed_q, armed_d;

   // armed_q stays low until a genuine low sample is seen, so an input that
   // is already high at reset release cannot masquerade as a rising edge.
   always_comb begin
      sync1_d  = async_in;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      vld_d    = 1'b1;
      armed_d  = armed_q | (vld_q & ~sync1_q);
      tick_out = sync2_q & ~prev_q & armed_q;
   end

   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         vld_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         vld_q   <= vld_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Game countdown timer: loads GAME_SECONDS on startGame, decrements on each
// enabled 1 Hz tick, latches timer_expired at zero. Binary and BCD outputs.
module countdown_timer
   import game_pkg::*;
#(
   parameter int GAME_SECONDS = GAME_SECONDS_DEF
) (
   input  logic       clkIn,
   input  logic       reset,
   input  logic       incrementClk,
   input  logic       startGame,
   input  logic       game_active,
   output logic       timer_expired,
   output logic [5:0] seconds_left,
   output logic [3:0] tens_bcd,
   output logic [3:0] ones_bcd,
   output logic       counting
);

   localparam logic [5:0] LOAD_SECS = 6'(GAME_SECONDS);
   localparam logic [3:0] LOAD_TENS = bcd_tens(GAME_SECONDS);
   localparam logic [3:0] LOAD_ONES = bcd_ones(GAME_SECONDS);

   logic tick;

   tick_sync u_tick_sync (
      .clkIn    (clkIn),
      .reset    (reset),
      .async_in (incrementClk),
      .tick_out (tick)
   );

   timer_state_t state_q, state_d;
   logic [5:0]   secs_q,  secs_d;
   logic [3:0]   tens_q,  tens_d;
   logic [3:0]   ones_q,  ones_d;
   logic         expired_q, expired_d;
   logic         counting_q, counting_d;
   logic         load;

   always_comb begin
      state_d   = state_q;
      secs_d    = secs_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      expired_d = expired_q;
      load      = 1'b0;

      case (state_q)
         IDLE, EXPIRED: begin
            // A tick coincident with the load is simply dropped.
            if (startGame) load = 1'b1;
         end
         COUNT: begin
            if (tick && game_active) begin
               secs_d = secs_q - 6'd1;
               if (ones_q == 4'd0) begin
                  ones_d = 4'd9;
                  tens_d = tens_q - 4'd1;
               end else begin
                  ones_d = ones_q - 4'd1;
               end
               if (secs_q == 6'd1) begin
                  state_d   = EXPIRED;
                  expired_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            secs_d    = LOAD_SECS;
            tens_d    = LOAD_TENS;
            ones_d    = LOAD_ONES;
            expired_d = 1'b0;
         end
      endcase

      if (load) begin
         state_d   = COUNT;
         secs_d    = LOAD_SECS;
         tens_d    = LOAD_TENS;
         ones_d    = LOAD_ONES;
         expired_d = 1'b0;
      end

      counting_d = (state_d == COUNT);
   end

   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         secs_q     <= LOAD_SECS;
         tens_q     <= LOAD_TENS;
         ones_q     <= LOAD_ONES;
         expired_q  <= 1'b0;
         counting_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         secs_q     <= secs_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         expired_q  <= expired_d;
         counting_q <= counting_d;
      end
   end

   assign timer_expired = expired_q;
   assign seconds_left  = secs_q;
   assign tens_bcd      = tens_q;
   assign ones_bcd      = ones_q;
   assign counting      = counting_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: a 3-second timer driven from a vector table plus hand
// sequences, and a 30-second timer for the BCD borrow walk.
module tb_countdown_timer;

   localparam int OP_START = 0;
   localparam int OP_TICK  = 1;

   logic       clk = 1'b0;
   logic       reset, rst30;
   logic       incrementClk, startGame, game_active;
   logic       e3, c3, e30, c30;
   logic [5:0] s3, s30;
   logic [3:0] t3, o3, t30, o30;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   countdown_timer #(.GAME_SECONDS(3)) dut3 (
      .clkIn(clk), .reset(reset), .incrementClk(incrementClk),
      .startGame(startGame), .game_active(game_active),
      .timer_expired(e3), .seconds_left(s3), .tens_bcd(t3),
      .ones_bcd(o3), .counting(c3)
   );

   countdown_timer #(.GAME_SECONDS(30)) dut30 (
      .clkIn(clk), .reset(rst30), .incrementClk(incrementClk),
      .startGame(startGame), .game_active(game_active),
      .timer_expired(e30), .seconds_left(s30), .tens_bcd(t30),
      .ones_bcd(o30), .counting(c30)
   );

   typedef struct {
      int   op;
      logic act;
      int   secs;
      logic expd;
      logic cnt;
   } vec_t;

   vec_t vt[10];

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic pulse_start();
      startGame = 1'b1;
      cyc(1);
      startGame = 1'b0;
      cyc(3);
   endtask

   task automatic do_tick();
      incrementClk = 1'b1;
      cyc(4);
      incrementClk = 1'b0;
      cyc(4);
   endtask

   task automatic chk3(input string nm, input int secs, input logic expd, input logic cnt);
      chk({nm, ".secs"}, 32'(s3), 32'(secs));
      chk({nm, ".tens"}, 32'(t3), 32'(secs / 10));
      chk({nm, ".ones"}, 32'(o3), 32'(secs % 10));
      chk({nm, ".expired"}, 32'(e3), 32'(expd));
      chk({nm, ".counting"}, 32'(c3), 32'(cnt));
   endtask

   initial begin
      vt[0] = '{OP_TICK,  1'b1, 3, 1'b0, 1'b0};  // idle ignores tick
      vt[1] = '{OP_START, 1'b1, 3, 1'b0, 1'b1};
      vt[2] = '{OP_TICK,  1'b1, 2, 1'b0, 1'b1};
      vt[3] = '{OP_START, 1'b1, 2, 1'b0, 1'b1};  // no mid-game restart
      vt[4] = '{OP_TICK,  1'b0, 2, 1'b0, 1'b1};
      vt[5] = '{OP_TICK,  1'b0, 2, 1'b0, 1'b1};
      vt[6] = '{OP_TICK,  1'b1, 1, 1'b0, 1'b1};
      vt[7] = '{OP_TICK,  1'b1, 0, 1'b1, 1'b0};
      vt[8] = '{OP_TICK,  1'b1, 0, 1'b1, 1'b0};  // no wrap in EXPIRED
      vt[9] = '{OP_START, 1'b1, 3, 1'b0, 1'b1};

      reset = 1'b1; rst30 = 1'b1;
      incrementClk = 1'b0; startGame = 1'b0; game_active = 1'b1;
      #2;
      reset = 1'b0; rst30 = 1'b0;
      #1;
      chk3("reset3", 3, 1'b0, 1'b0);
      chk("reset30.secs", 32'(s30), 32'd30);
      chk("reset30.tens", 32'(t30), 32'd3);
      chk("reset30.ones", 32'(o30), 32'd0);
      cyc(3);
      reset = 1'b1;
      cyc(2);

      for (int i = 0; i < 10; i++) begin
         game_active = vt[i].act;
         if (vt[i].op == OP_START) pulse_start();
         else do_tick();
         chk3($sformatf("vec%0d", i), vt[i].secs, vt[i].expd, vt[i].cnt);
      end
      game_active = 1'b1;

      // Tick latency: rise sampled at edge N lands at edge N+2.
      incrementClk = 1'b1;
      cyc(1);
      chk("lat.N", 32'(s3), 32'd3);
      cyc(1);
      chk("lat.N+1", 32'(s3), 32'd3);
      cyc(1);
      chk("lat.N+2", 32'(s3), 32'd2);
      incrementClk = 1'b0;
      cyc(4);

      // Run to zero, then load coincident with a tick.
      do_tick();
      do_tick();
      chk3("expire", 0, 1'b1, 1'b0);
      incrementClk = 1'b1;
      cyc(2);
      startGame = 1'b1;
      cyc(1);
      startGame = 1'b0;
      chk3("coincide", 3, 1'b0, 1'b1);
      incrementClk = 1'b0;
      cyc(4);
      chk("coincide.after", 32'(s3), 32'd3);

      // Asynchronous abort mid-count, checked before the next clock edge.
      do_tick();
      chk("pre_abort", 32'(s3), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      chk3("abort", 3, 1'b0, 1'b0);

      // Release with incrementClk already high: no tick until a fresh rise.
      incrementClk = 1'b1;
      cyc(2);
      reset = 1'b1;
      startGame = 1'b1;
      cyc(1);
      startGame = 1'b0;
      cyc(6);
      chk3("hi_release", 3, 1'b0, 1'b1);
      incrementClk = 1'b0;
      cyc(4);
      chk("hi_release.low", 32'(s3), 32'd3);
      do_tick();
      chk("hi_release.rise", 32'(s3), 32'd2);

      // 30-second BCD walk through the tens borrow.
      rst30 = 1'b1;
      cyc(2);
      pulse_start();
      chk("bcd.load.secs", 32'(s30), 32'd30);
      chk("bcd.load.tens", 32'(t30), 32'd3);
      chk("bcd.load.ones", 32'(o30), 32'd0);
      for (int k = 1; k <= 11; k++) begin
         do_tick();
         chk($sformatf("bcd%0d.secs", k), 32'(s30), 32'(30 - k));
         chk($sformatf("bcd%0d.tens", k), 32'(t30), 32'((30 - k) / 10));
         chk($sformatf("bcd%0d.ones", k), 32'(o30), 32'((30 - k) % 10));
      end
      chk("bcd.counting", 32'(c30), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
